// File: rtl/snn_layer_lif.sv
// Fully-connected layer of leaky integrate-and-fire neurons. Every output neuron sees all
// input channels through its own signed weights; spikes, potentials and refractory flags are registered.
module snn_layer_lif #(
    parameter int N_IN        = 3,
    parameter int N_OUT       = 2,
    parameter int W_W         = 4,
    parameter int V_W         = 8,
    parameter int THRESH      = 16,
    parameter int REFRACTORY  = 2,
    parameter int LEAK_PERIOD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_IN-1:0]             spike_in,
    input  logic [N_IN-1:0]             sign_in,
    input  logic [N_OUT*N_IN*W_W-1:0]   weight,
    output logic [N_OUT-1:0]            spike_out,
    output logic [N_OUT*V_W-1:0]        potential,
    output logic [N_OUT-1:0]            refr_busy
);

    localparam int S_W  = W_W + 1 + $clog2(N_IN);
    localparam int E_W  = ((V_W > S_W) ? V_W : S_W) + 1;
    localparam int LC_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int R_W  = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic signed [E_W-1:0] V_MAX   = E_W'((2 ** (V_W - 1)) - 1);
    localparam logic signed [E_W-1:0] V_MIN   = E_W'(-(2 ** (V_W - 1)));
    localparam logic signed [V_W-1:0] V_TH    = V_W'(THRESH);
    localparam logic signed [V_W-1:0] V_ONE   = V_W'(1);
    localparam logic [R_W-1:0]        R_LOAD  = R_W'(REFRACTORY);
    localparam logic [LC_W-1:0]       LC_LAST = LC_W'((LEAK_PERIOD > 0) ? LEAK_PERIOD - 1 : 0);

    logic [LC_W-1:0] leak_cnt;
    logic            leak_tick;

    // The leak phase is shared by every neuron and only advances on enabled cycles.
    assign leak_tick = (LEAK_PERIOD != 0) && (leak_cnt == LC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leak_cnt <= '0;
        end else if (en && (LEAK_PERIOD != 0)) begin
            leak_cnt <= leak_tick ? '0 : leak_cnt + 1'b1;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        logic signed [V_W-1:0] v_q;
        logic signed [V_W-1:0] v_d;
        logic [R_W-1:0]        r_q;
        logic [R_W-1:0]        r_d;
        logic                  spk_q;
        logic                  spk_d;
        logic                  busy_q;
        logic                  busy_d;
        logic signed [S_W-1:0] sum;
        logic signed [E_W-1:0] v_ext;
        logic signed [E_W-1:0] s_ext;
        logic signed [E_W-1:0] v_sum;
        logic signed [V_W-1:0] v1;
        logic signed [V_W-1:0] v2;

        always_comb begin : c_sum
            logic signed [W_W-1:0] w;
            logic signed [S_W-1:0] c;
            sum = '0;
            w   = '0;
            c   = '0;
            for (int i = 0; i < N_IN; i++) begin
                w = weight[(j*N_IN+i)*W_W +: W_W];
                c = w;
                if (sign_in[i]) begin
                    c = -c;
                end
                if (spike_in[i]) begin
                    sum = sum + c;
                end
            end
        end

        always_comb begin : c_update
            v_ext = v_q;
            s_ext = sum;
            v_sum = v_ext + s_ext;

            if (v_sum > V_MAX) begin
                v1 = V_MAX[V_W-1:0];
            end else if (v_sum < V_MIN) begin
                v1 = V_MIN[V_W-1:0];
            end else begin
                v1 = v_sum[V_W-1:0];
            end

            // Leak moves one step toward zero and can never cross it.
            v2 = v1;
            if (leak_tick) begin
                if (v1[V_W-1]) begin
                    v2 = v1 + V_ONE;
                end else if (v1 != '0) begin
                    v2 = v1 - V_ONE;
                end
            end

            r_d    = r_q;
            v_d    = v_q;
            spk_d  = 1'b0;
            busy_d = busy_q;
            if (r_q != '0) begin
                r_d    = r_q - 1'b1;
                v_d    = '0;
                busy_d = (r_d != '0);
            end else if (v2 >= V_TH) begin
                v_d    = '0;
                spk_d  = 1'b1;
                r_d    = R_LOAD;
                busy_d = (REFRACTORY != 0);
            end else begin
                v_d = v2;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q    <= '0;
                r_q    <= '0;
                spk_q  <= 1'b0;
                busy_q <= 1'b0;
            end else if (en) begin
                v_q    <= v_d;
                r_q    <= r_d;
                spk_q  <= spk_d;
                busy_q <= busy_d;
            end else begin
                spk_q  <= 1'b0;
            end
        end

        assign spike_out[j]              = spk_q;
        assign refr_busy[j]              = busy_q;
        assign potential[j*V_W +: V_W]   = v_q;
    end

endmodule

// File: tb/tb_snn_layer_lif.sv
// Scoreboard bench for snn_layer_lif: a driver feeds directed and random spike patterns
// and queues the reference model's expectation; a monitor compares after each rising edge.
module tb_snn_layer_lif;

    localparam int N_IN        = 3;
    localparam int N_OUT       = 2;
    localparam int W_W         = 4;
    localparam int V_W         = 8;
    localparam int THRESH      = 16;
    localparam int REFRACTORY  = 2;
    localparam int LEAK_PERIOD = 4;
    localparam int VMAX        = (1 << (V_W - 1)) - 1;
    localparam int VMIN        = -(1 << (V_W - 1));

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       en = 1'b0;
    logic [N_IN-1:0]            spike_in = '0;
    logic [N_IN-1:0]            sign_in = '0;
    logic [N_OUT*N_IN*W_W-1:0]  weight = '0;
    logic [N_OUT-1:0]           spike_out;
    logic [N_OUT*V_W-1:0]       potential;
    logic [N_OUT-1:0]           refr_busy;

    always #5 clk = ~clk;

    snn_layer_lif #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .V_W(V_W),
        .THRESH(THRESH), .REFRACTORY(REFRACTORY), .LEAK_PERIOD(LEAK_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .spike_in(spike_in), .sign_in(sign_in), .weight(weight),
        .spike_out(spike_out), .potential(potential), .refr_busy(refr_busy)
    );

    typedef struct {
        logic [N_OUT-1:0]     spk;
        logic [N_OUT*V_W-1:0] pot;
        logic [N_OUT-1:0]     busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain integer view of each neuron
    int   wt[N_OUT][N_IN];
    int   mv[N_OUT];
    int   mr[N_OUT];
    bit   mspk[N_OUT];
    bit   mbusy[N_OUT];
    int   mlc;

    function automatic void check_vec(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < N_OUT; j++) begin
            mv[j] = 0; mr[j] = 0; mspk[j] = 1'b0; mbusy[j] = 1'b0;
        end
        mlc = 0;
    endfunction

    function automatic void model_step(input bit e, input logic [N_IN-1:0] s, input logic [N_IN-1:0] g);
        bit tick;
        int sum;
        int v;
        for (int j = 0; j < N_OUT; j++) mspk[j] = 1'b0;
        if (!e) return;
        tick = 1'b0;
        if (LEAK_PERIOD > 0) begin
            tick = (mlc == LEAK_PERIOD - 1);
            mlc  = tick ? 0 : mlc + 1;
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (mr[j] > 0) begin
                mr[j]--;
                mv[j]    = 0;
                mbusy[j] = (mr[j] != 0);
                continue;
            end
            sum = 0;
            for (int i = 0; i < N_IN; i++)
                if (s[i]) sum += g[i] ? -wt[j][i] : wt[j][i];
            v = mv[j] + sum;
            if (v > VMAX) v = VMAX;
            if (v < VMIN) v = VMIN;
            if (tick) begin
                if (v > 0) v--;
                else if (v < 0) v++;
            end
            if (v >= THRESH) begin
                mspk[j] = 1'b1; mv[j] = 0; mr[j] = REFRACTORY; mbusy[j] = (REFRACTORY != 0);
            end else begin
                mv[j] = v;
            end
        end
    endfunction

    function automatic exp_t model_expect();
        exp_t x;
        for (int j = 0; j < N_OUT; j++) begin
            x.spk[j]              = mspk[j];
            x.busy[j]             = mbusy[j];
            x.pot[j*V_W +: V_W]   = V_W'(mv[j]);
        end
        return x;
    endfunction

    task automatic load_weights();
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                weight[(j*N_IN+i)*W_W +: W_W] = W_W'(wt[j][i]);
    endtask

    task automatic random_weights();
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++)
                wt[j][i] = int'($urandom_range(15)) - 8;
    endtask

    task automatic cycle(input bit e, input logic [N_IN-1:0] s, input logic [N_IN-1:0] g);
        @(negedge clk);
        en = e; spike_in = s; sign_in = g;
        model_step(e, s, g);
        exp_q.push_back(model_expect());
    endtask

    // Reset lands between edges; outputs must clear with no clock edge in between.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; spike_in = '0; sign_in = '0;
        #1;
        check_vec("rst_potential", potential, '0);
        check_vec("rst_spike_out", spike_out, '0);
        check_vec("rst_refr_busy", refr_busy, '0);
        model_reset();
        load_weights();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            cur_exp = exp_q.pop_front();
            check_vec("spike_out", spike_out, cur_exp.spk);
            check_vec("potential", potential, cur_exp.pot);
            check_vec("refr_busy", refr_busy, cur_exp.busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        random_weights();

        // Integrate and fire: 5,10,15 then 20 leaks to 19 and fires
        wt[0][0] = 5; wt[0][1] = 0; wt[0][2] = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 3'b001, 3'b000);
            settle();
            check_vec("iaf_pot0", potential[V_W-1:0], 64'(8'(5 * (k + 1))));
        end
        cycle(1'b1, 3'b001, 3'b000);
        settle();
        check_vec("iaf_fire", spike_out[0], 1'b1);
        check_vec("iaf_fire_pot0", potential[V_W-1:0], 8'h00);
        check_vec("iaf_fire_busy", refr_busy[0], 1'b1);
        cycle(1'b1, 3'b001, 3'b000);
        settle();
        check_vec("iaf_refr_busy", refr_busy[0], 1'b1);
        check_vec("iaf_refr_pot0", potential[V_W-1:0], 8'h00);
        cycle(1'b1, 3'b001, 3'b000);
        for (int k = 0; k < 6; k++) cycle(1'b1, 3'b001, 3'b000);

        // Mid-run reset from potential 10
        do_reset();
        cycle(1'b1, 3'b001, 3'b000);
        cycle(1'b1, 3'b001, 3'b000);
        settle();
        check_vec("pre_rst_pot0", potential[V_W-1:0], 8'd10);

        // Collision: 3 - 4 - 2 = -3
        wt[0][0] = 3; wt[0][1] = 4; wt[0][2] = -2;
        do_reset();
        cycle(1'b1, 3'b111, 3'b010);
        settle();
        check_vec("collision_pot0", potential[V_W-1:0], 8'hFD);
        for (int k = 0; k < 4; k++) cycle(1'b1, 3'($urandom_range(7)), 3'($urandom_range(7)));

        // Negative floor
        wt[0][0] = -8; wt[0][1] = -8; wt[0][2] = -8;
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b1, 3'b111, 3'b000);
        settle();
        check_vec("floor_pot0", potential[V_W-1:0], 8'h80);

        // Leak toward zero from both sides
        wt[0][0] = 6;
        do_reset();
        cycle(1'b1, 3'b001, 3'b000);
        for (int k = 0; k < 30; k++) cycle(1'b1, 3'b000, 3'b000);
        settle();
        check_vec("leak_pos_end", potential[V_W-1:0], 8'h00);
        wt[0][0] = -3;
        do_reset();
        cycle(1'b1, 3'b001, 3'b000);
        for (int k = 0; k < 16; k++) cycle(1'b1, 3'b000, 3'b000);

        // en gating mid leak phase and mid refractory
        wt[0][0] = 7; wt[1][0] = 6; wt[1][1] = 7;
        do_reset();
        cycle(1'b1, 3'b001, 3'b000);
        cycle(1'b1, 3'b011, 3'b000);
        for (int k = 0; k < 10; k++) cycle(1'b0, 3'b111, 3'b000);
        for (int k = 0; k < 3; k++) cycle(1'b1, 3'b000, 3'b000);
        cycle(1'b1, 3'b011, 3'b000);
        for (int k = 0; k < 10; k++) cycle(1'b0, 3'b011, 3'b000);
        for (int k = 0; k < 12; k++) cycle(1'b1, 3'b000, 3'b000);

        // Random rounds
        for (int r = 0; r < 5; r++) begin
            random_weights();
            do_reset();
            for (int k = 0; k < 400; k++)
                cycle($urandom_range(9) != 0, 3'($urandom_range(7)), 3'($urandom_range(7)));
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snn_layer_lif.md
Name: snn_layer_lif

Overview:
- Parametrised fully-connected spiking layer: N_IN signed spike inputs fan out to N_OUT leaky integrate-and-fire neurons.
- Each synapse has its own signed weight.
- Simultaneous input spikes are summed; no collision-free input is required.
- Adds per-neuron membrane accumulator, threshold firing, refractory hold-off and periodic leak.
- Sits between spike-encoding front end and the next layer; spike_out drives the next layer's spike_in directly.

Parameters:
- N_IN, 3, number of input channels
- N_OUT, 2, number of neurons
- W_W, 4, synapse weight width (signed two's complement)
- V_W, 8, membrane potential width (signed)
- THRESH, 16, firing threshold (positive, < 2^(V_W-1))
- REFRACTORY, 2, cycles a neuron ignores input after firing (0 = none)
- LEAK_PERIOD, 4, leak applied every LEAK_PERIOD enabled cycles (0 = leak disabled)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  layer enable; low freezes all state
- spike_in  input  N_IN  spike on channel i this cycle
- sign_in  input  N_IN  1 = inhibitory, negates the weight for channel i
- weight  input  N_OUT*N_IN*W_W  weight for neuron j, input i at bits [(j*N_IN+i)*W_W +: W_W]; held static during operation
- spike_out  output  N_OUT  registered spike, one cycle wide
- potential  output  N_OUT*V_W  registered membrane potential of neuron j at [j*V_W +: V_W] (debug/verification)
- refr_busy  output  N_OUT  neuron j is in refractory

Behaviour:
Reset:
- rst asserted: spike_out=0, potential=0, refr_busy=0, refractory counters=0, leak counter=0.
- Reset takes effect immediately (async) and mid-operation discards all state.

en low:
- No state change, including the leak counter.
- spike_out driven 0 on the next edge.

Leak counter:
- Counts 0..LEAK_PERIOD-1 on enabled cycles.
- leak_tick = (counter == LEAK_PERIOD-1); counter wraps to 0 on that cycle.

Per neuron j, each enabled cycle:
- Contribution of channel i = spike_in[i] ? (sign_in[i] ? -w_ji : w_ji) : 0.
  - Computed at W_W+1 bits so that -(-2^(W_W-1)) is exact.
- sum = signed sum over i, width W_W+1+clog2(N_IN); no overflow possible.
- If refr count > 0:
  - input ignored, potential stays 0;
  - count decrements;
  - refr_busy = (new count != 0);
  - spike_out = 0.
- Else:
  - v1 = saturate(v + sum) to [-(2^(V_W-1)), 2^(V_W-1)-1].
  - On leak_tick: v2 = v1 moved one step toward 0 (v1>0: -1; v1<0: +1; 0 stays); otherwise v2 = v1.
  - If v2 >= THRESH: spike_out=1, potential=0, refr count=REFRACTORY, refr_busy=(REFRACTORY!=0).
  - Else: spike_out=0, potential=v2.

Latency:
- Input spike at edge k appears as spike_out at edge k+1, i.e. one registered cycle.
- With REFRACTORY=R, the earliest re-fire is R+1 cycles after a spike.
- With REFRACTORY=0, a neuron may fire on consecutive cycles.

Boundaries:
- Excitatory and inhibitory spikes arriving in the same cycle sum algebraically.
- Negative potential saturates at the minimum value; it never wraps.
- Leak never crosses zero.
- Leak tick is shared by all neurons; a neuron in refractory on a tick does not leak (its potential is 0).
- Firing is decided on the post-leak value.

Test Plan:
- Reset mid-run: neuron at potential=10, assert rst between edges -> potential=0, spike_out=0 immediately, with no clock edge.
- Integrate and fire, LEAK_PERIOD=0, w00=5, spike_in[0] held 4 cycles -> potential 5,10,15, then spike_out[0]=1 with potential=0 on the 4th edge; refr_busy[0]=1 for the following 2 edges, during which inputs are ignored.
- Collision sum: w00=3, w01=4, w02=-2, all spike_in=1, sign_in=3'b010 -> sum=3-4-2=-3, potential[0]=-3 after one edge.
- Saturation: weights +7 on all inputs, THRESH=127, V_W=8, spiking every cycle -> potential saturates at 127 and fires.
  - Separately, weights -8 with sign_in=0 -> potential floors at -128, never wraps positive.
- Leak: LEAK_PERIOD=4, one spike w00=6, then idle -> potential 6, then 5 at the first tick, decrementing by 1 every 4 cycles to 0 and holding at 0.
  - Repeat with w00=-3 -> rises by 1 per tick to 0.
- en gating: en=0 for 10 cycles with spikes present -> potential, leak counter and refractory counters unchanged, spike_out=0; resuming en continues the leak phase exactly where it stopped.
